// File: rtl/usbf_ep_buf_upd.sv
`default_nettype none
// ============================================================================
//  Module   : usbf_ep_buf_upd
//  Purpose  : Buffer-descriptor update engine. After each USB data transfer
//             it selects the endpoint register file, reads the buffer in use,
//             writes back the advanced pointer and remaining size, reloads
//             (buf0) or retires (buf1) exhausted buffers and raises the
//             matching interrupt strobes.
//  Ports    : clk, rst_n (async active-low)
//             upd_req/upd_ep/upd_bsel/upd_cnt/upd_crc_err/upd_tout : request
//             upd_ack/upd_nobuf/upd_ovr                            : completion
//             ep_sel/ep_match/csr/buf0/buf1/idin                   : RF side
//             buf0_set/buf1_set/buf0_rl                            : RF strobes
//             int_buf0_set/int_buf1_set/int_crc16_set/int_to_set   : interrupts
//  Params   : MATCH_TO - cycles to wait for ep_match before giving up (1..255)
//  Config   : USBF_UPD_ERRINT_EN - when defined, CRC16/timeout flags of the
//             transfer are forwarded as interrupt strobes.
//  Note     : csr is part of the RF interface but no csr field steers this
//             engine.
//  Revision : 1.0 - initial release
// ============================================================================
module usbf_ep_buf_upd #(
  parameter int MATCH_TO = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_req,
  input  logic [3:0]  upd_ep,
  input  logic        upd_bsel,
  input  logic [13:0] upd_cnt,
  input  logic        upd_crc_err,
  input  logic        upd_tout,
  output logic        upd_ack,
  output logic        upd_nobuf,
  output logic        upd_ovr,
  output logic [3:0]  ep_sel,
  input  logic        ep_match,
  input  logic [31:0] csr,
  input  logic [31:0] buf0,
  input  logic [31:0] buf1,
  output logic [31:0] idin,
  output logic        buf0_set,
  output logic        buf1_set,
  output logic        buf0_rl,
  output logic        int_buf0_set,
  output logic        int_buf1_set,
  output logic        int_crc16_set,
  output logic        int_to_set
);

  localparam logic [7:0]  c_to_last = 8'(MATCH_TO - 1);
  localparam logic [31:0] c_buf_inv = 32'hffff_ffff;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_CALC = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_bsel;
  logic [13:0] r_cnt;
  logic [31:0] r_buf;
  logic [7:0]  r_to;
  logic        r_ovr;
  logic        r_crc;
  logic        r_tout;

  logic [13:0] w_size;
  logic [16:0] w_ptr;
  logic        w_ovr;
  logic [13:0] w_new_size;
  logic [16:0] w_new_ptr;
  logic        w_invalid;
  logic        w_crc_int;
  logic        w_to_int;

  // Descriptor arithmetic on the captured buffer word.
  assign w_size     = r_buf[30:17];
  assign w_ptr      = r_buf[16:0];
  assign w_ovr      = (r_cnt > w_size);
  assign w_new_size = w_ovr ? 14'd0 : (w_size - r_cnt);
  assign w_new_ptr  = w_ptr + {3'b000, r_cnt};   // wraps modulo 2^17
  assign w_invalid  = (r_buf == c_buf_inv);

`ifdef USBF_UPD_ERRINT_EN
  assign w_crc_int = r_crc;
  assign w_to_int  = r_tout;
`else
  assign w_crc_int = 1'b0;
  assign w_to_int  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_bsel        <= 1'b0;
      r_cnt         <= 14'd0;
      r_buf         <= 32'h0;
      r_to          <= 8'd0;
      r_ovr         <= 1'b0;
      r_crc         <= 1'b0;
      r_tout        <= 1'b0;
      ep_sel        <= 4'h0;
      idin          <= 32'h0;
      upd_ack       <= 1'b0;
      upd_nobuf     <= 1'b0;
      upd_ovr       <= 1'b0;
      buf0_set      <= 1'b0;
      buf1_set      <= 1'b0;
      buf0_rl       <= 1'b0;
      int_buf0_set  <= 1'b0;
      int_buf1_set  <= 1'b0;
      int_crc16_set <= 1'b0;
      int_to_set    <= 1'b0;
    end else begin
      // All strobes and completion flags are single-cycle pulses.
      upd_ack       <= 1'b0;
      upd_nobuf     <= 1'b0;
      upd_ovr       <= 1'b0;
      buf0_set      <= 1'b0;
      buf1_set      <= 1'b0;
      buf0_rl       <= 1'b0;
      int_buf0_set  <= 1'b0;
      int_buf1_set  <= 1'b0;
      int_crc16_set <= 1'b0;
      int_to_set    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (upd_req) begin
            ep_sel  <= upd_ep;
            r_bsel  <= upd_bsel;
            r_cnt   <= upd_cnt;
`ifdef USBF_UPD_ERRINT_EN
            r_crc   <= upd_crc_err;
            r_tout  <= upd_tout;
`endif
            r_to    <= 8'd0;
            r_ovr   <= 1'b0;
            r_state <= S_SEL;
          end
        end

        S_SEL: begin
          if (ep_match) begin
            r_buf   <= r_bsel ? buf1 : buf0;
            r_state <= S_CALC;
          end else if (r_to == c_to_last) begin
            // No RF answered: dummy endpoint, finish without writing.
            upd_ack       <= 1'b1;
            upd_nobuf     <= 1'b1;
            int_crc16_set <= w_crc_int;
            int_to_set    <= w_to_int;
            r_state       <= S_DONE;
          end else begin
            r_to <= r_to + 8'd1;
          end
        end

        S_CALC: begin
          if (w_invalid) begin
            upd_ack       <= 1'b1;
            upd_nobuf     <= 1'b1;
            int_crc16_set <= w_crc_int;
            int_to_set    <= w_to_int;
            r_state       <= S_DONE;
          end else begin
            r_ovr         <= w_ovr;
            int_crc16_set <= w_crc_int;
            int_to_set    <= w_to_int;
            r_state       <= S_WR;
            if (w_new_size != 14'd0) begin
              buf0_set <= ~r_bsel;
              buf1_set <= r_bsel;
              idin     <= {1'b0, w_new_size, w_new_ptr};
            end else if (!r_bsel) begin
              // buf0 exhausted: RF restores its original descriptor.
              buf0_rl      <= 1'b1;
              int_buf0_set <= 1'b1;
              idin         <= {1'b0, 14'd0, w_new_ptr};
            end else begin
              // buf1 exhausted: retire it by marking it invalid.
              buf1_set     <= 1'b1;
              int_buf1_set <= 1'b1;
              idin         <= c_buf_inv;
            end
          end
        end

        S_WR: begin
          upd_ack <= 1'b1;
          upd_ovr <= r_ovr;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usbf_ep_buf_upd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usbf_ep_buf_upd
//  Purpose  : Self-checking bench for usbf_ep_buf_upd. A behavioural RF
//             array model answers endpoint selects; expected descriptors,
//             strobes and completion timing come from integer arithmetic on
//             the transfer rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usbf_ep_buf_upd;

  localparam int MATCH_TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_req = 1'b0;
  logic [3:0]  upd_ep = 4'h0;
  logic        upd_bsel = 1'b0;
  logic [13:0] upd_cnt = 14'd0;
  logic        upd_crc_err = 1'b0;
  logic        upd_tout = 1'b0;
  logic        upd_ack, upd_nobuf, upd_ovr;
  logic [3:0]  ep_sel;
  logic        ep_match;
  logic [31:0] csr, buf0, buf1, idin;
  logic        buf0_set, buf1_set, buf0_rl;
  logic        int_buf0_set, int_buf1_set, int_crc16_set, int_to_set;

  // Endpoint register-file model.
  logic [31:0] rf0 [16];
  logic [31:0] rf1 [16];
  logic        present [16];

  assign buf0     = rf0[ep_sel];
  assign buf1     = rf1[ep_sel];
  assign ep_match = present[ep_sel];
  assign csr      = {28'h0, ep_sel};

  int checks = 0;
  int errors = 0;

  usbf_ep_buf_upd #(.MATCH_TO(MATCH_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_req(upd_req), .upd_ep(upd_ep), .upd_bsel(upd_bsel), .upd_cnt(upd_cnt),
    .upd_crc_err(upd_crc_err), .upd_tout(upd_tout),
    .upd_ack(upd_ack), .upd_nobuf(upd_nobuf), .upd_ovr(upd_ovr),
    .ep_sel(ep_sel), .ep_match(ep_match), .csr(csr), .buf0(buf0), .buf1(buf1),
    .idin(idin), .buf0_set(buf0_set), .buf1_set(buf1_set), .buf0_rl(buf0_rl),
    .int_buf0_set(int_buf0_set), .int_buf1_set(int_buf1_set),
    .int_crc16_set(int_crc16_set), .int_to_set(int_to_set)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] strobes();
    return {buf0_set, buf1_set, buf0_rl, int_buf0_set, int_buf1_set, int_crc16_set, int_to_set};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkbuf(input int size, input int ptr);
    logic [13:0] s;
    logic [16:0] p;
    s = 14'(size);
    p = 17'(ptr);
    return {1'b0, s, p};
  endfunction

  // Issue one request and check every cycle until the expected ack.
  task automatic run_req(input logic [3:0] ep, input logic bsel, input int cnt,
                         input logic crc, input logic tout, input bit drop_early);
    logic [31:0] bv;
    int          size, ptr, rem, nptr, ack_c;
    bit          nobuf, ovr, chk_idin;
    logic [6:0]  wr_str, err_str, exp_str;
    logic [31:0] exp_idin;

    bv = bsel ? rf1[ep] : rf0[ep];
    nobuf = 0; ovr = 0; chk_idin = 0; wr_str = 7'b0; exp_idin = 32'h0; err_str = 7'b0;
`ifdef USBF_UPD_ERRINT_EN
    err_str = {5'b0, crc, tout};
`endif
    if (!present[ep]) begin
      nobuf = 1; ack_c = MATCH_TO + 1;
    end else if (bv == 32'hffff_ffff) begin
      nobuf = 1; ack_c = 3;
    end else begin
      ack_c = 4;
      size  = int'(bv[30:17]);
      ptr   = int'(bv[16:0]);
      rem   = size - cnt;
      ovr   = (rem < 0);
      if (rem < 0) rem = 0;
      nptr  = (ptr + cnt) % 131072;
      if (rem > 0) begin
        wr_str = bsel ? 7'b0100000 : 7'b1000000;
        exp_idin = mkbuf(rem, nptr);
        chk_idin = 1;
      end else if (!bsel) begin
        wr_str = 7'b0011000;
      end else begin
        wr_str = 7'b0101000 & 7'b0100000 | 7'b0000100;
        exp_idin = 32'hffff_ffff;
        chk_idin = 1;
      end
    end

    @(negedge clk);
    upd_req = 1'b1; upd_ep = ep; upd_bsel = bsel; upd_cnt = 14'(cnt);
    upd_crc_err = crc; upd_tout = tout;
    for (int c = 1; c <= ack_c; c++) begin
      @(negedge clk);
      if (drop_early && c == 1) upd_req = 1'b0;
      exp_str = 7'b0;
      if (!nobuf && c == 3) exp_str = wr_str | err_str;
      if (nobuf && c == ack_c) exp_str = err_str;
      check($sformatf("strobes ep%0d c%0d", ep, c), 64'(strobes()), 64'(exp_str));
      check($sformatf("ack ep%0d c%0d", ep, c), 64'(upd_ack), 64'(c == ack_c));
      if (c == 1 || c == ack_c) check("ep_sel", 64'(ep_sel), 64'(ep));
      if (chk_idin && c == 3) check("idin", 64'(idin), 64'(exp_idin));
      if (c == ack_c) begin
        check("nobuf", 64'(upd_nobuf), 64'(nobuf));
        check("ovr", 64'(upd_ovr), 64'(ovr));
      end
    end
    upd_req = 1'b0;
    // Model the RF write (buf0 reload restores the same descriptor).
    if (chk_idin) begin
      if (bsel) rf1[ep] = exp_idin;
      else      rf0[ep] = exp_idin;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {18'b0, upd_ack, upd_nobuf, upd_ovr, strobes(), ep_sel, idin},
          64'h0);
  endtask

  // Start a request, assert reset in cycle at_c, then verify it was discarded.
  task automatic run_abort(input logic [3:0] ep, input int cnt, input int at_c);
    @(negedge clk);
    upd_req = 1'b1; upd_ep = ep; upd_bsel = 1'b0; upd_cnt = 14'(cnt);
    upd_crc_err = 1'b0; upd_tout = 1'b0;
    for (int c = 1; c <= at_c; c++) @(negedge clk);
    rst_n = 1'b0;
    upd_req = 1'b0;
    #1;
    check_all_zero($sformatf("reset abort c%0d", at_c));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("post-reset quiet", {57'b0, upd_ack, strobes()}, 64'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf0[i] = 32'hffff_ffff;
      rf1[i] = 32'hffff_ffff;
      present[i] = (i < 12);
    end

    // Reset state.
    #1;
    check_all_zero("reset outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle outputs");

    // 1: ordinary update on buf0.
    rf0[3] = mkbuf(64, 'h100);
    run_req(4'd3, 1'b0, 16, 1'b0, 1'b0, 0);
    check("ep3 buf0 after", 64'(rf0[3]), 64'(mkbuf(48, 'h110)));

    // 2: exhaust buf1 (retire) and buf0 (reload).
    rf1[5] = mkbuf(8, 'h40);
    run_req(4'd5, 1'b1, 8, 1'b0, 1'b0, 0);
    rf0[6] = mkbuf(8, 'h40);
    run_req(4'd6, 1'b0, 8, 1'b0, 1'b0, 0);

    // 3: dummy endpoint.
    run_req(4'd14, 1'b0, 5, 1'b0, 1'b0, 0);

    // 4: invalid buffer, then overrun into reload path.
    rf0[7] = 32'hffff_ffff;
    run_req(4'd7, 1'b0, 3, 1'b0, 1'b0, 0);
    rf0[8] = mkbuf(4, 'h20);
    run_req(4'd8, 1'b0, 10, 1'b0, 1'b0, 0);

    // 5: pointer wrap with error flags; zero count; zero size zero count.
    rf0[9] = mkbuf(100, 'h1FFF0);
    run_req(4'd9, 1'b0, 'h20, 1'b1, 1'b0, 0);
    rf1[10] = mkbuf(12, 'h777);
    run_req(4'd10, 1'b1, 0, 1'b0, 1'b1, 0);
    rf1[11] = mkbuf(0, 'h5);
    run_req(4'd11, 1'b1, 0, 1'b0, 1'b0, 0);
    run_req(4'd15, 1'b1, 1, 1'b1, 1'b1, 0);

    // Request dropped early still completes.
    rf1[2] = mkbuf(30, 'h10);
    run_req(4'd2, 1'b1, 7, 1'b0, 1'b0, 1);

    // 6: reset during SEL and during WR, then a normal request.
    rf0[4] = mkbuf(20, 'h300);
    run_abort(4'd4, 5, 1);
    run_abort(4'd4, 5, 3);
    check("rf0[4] untouched", 64'(rf0[4]), 64'(mkbuf(20, 'h300)));
    run_req(4'd4, 1'b0, 5, 1'b0, 1'b0, 0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      logic [3:0] ep;
      logic       bs;
      int         r, sz, pt, cn;
      ep = 4'($urandom_range(15, 0));
      bs = 1'($urandom_range(1, 0));
      r  = $urandom_range(9, 0);
      sz = $urandom_range(40, 0);
      pt = (r < 3) ? ('h1FFF0 + $urandom_range(15, 0)) : int'($urandom_range(131071, 0));
      cn = $urandom_range(48, 0);
      if (r == 0) begin
        if (bs) rf1[ep] = 32'hffff_ffff; else rf0[ep] = 32'hffff_ffff;
      end else begin
        if (bs) rf1[ep] = mkbuf(sz, pt); else rf0[ep] = mkbuf(sz, pt);
      end
      run_req(ep, bs, cn, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
